sub_bytes_engine: RTL and testbench
===================================

Name: sub_bytes_engine

Overview:
- Sequential, parametrised AES SubBytes / InvSubBytes engine for a full 128-bit state.
- Uses LANES byte-substitution units and iterates over the 16 state bytes in 16/LANES cycles.
- Per-transaction mode select: forward S-box or inverse S-box.
- Valid/ready handshake on input and output; sits between the AddRoundKey stage and the ShiftRows stage of the round datapath.

Parameters:
- LANES, 4: parallel byte-substitution units. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- NB, 16/LANES (derived, not overridable): processing cycles per block.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  state; byte i = in_data[8i+7:8i], i = 0..15.
- in_inv  in  1  0 = forward S-box (FIPS-197 Fig.7); 1 = inverse S-box (Fig.14). Sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  128  substituted state, same byte order as in_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, chunk counter=0, mode reg=0.
  - Data/result registers = 0.
  - in_ready=1, out_valid=0, out_data=128'h0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready at a clock edge: capture in_data into the work register, in_inv into the mode register, cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: bytes cnt*LANES .. cnt*LANES+LANES-1 of the work register are replaced in place by S(b) or S^-1(b) per the mode register; then cnt++.
  - When cnt==NB-1 at the edge, go to DONE (cnt returns to 0).
- DONE:
  - out_valid=1; out_data = work register, held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to IDLE.
  - No same-cycle input acceptance: in_ready is low in DONE.
- Latency:
  - out_valid rises NB edges after the accept edge. LANES=16 → 1; LANES=4 → 4; LANES=1 → 16.
  - Throughput is one block per NB+2 cycles when out_ready is held high.
- out_data stays at the last result after the output handshake, until the next block's DONE. It is registered, with no combinational path from in_data.
- Changes to in_inv or in_data outside the accept edge have no effect on a transaction in flight.
- in_valid while busy: ignored; the source must hold it until in_ready.
- out_ready while not out_valid: ignored.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded, and no out_valid pulse follows reset deassertion.
- Substitution tables:
  - Full 256-entry forward and inverse tables, combinational per lane.
  - S^-1(S(x)) = x for all x.
  - No X output for any 8-bit input.
- Parameter check: an illegal LANES value fails elaboration via a generate-time error.

Test Plan:
- Reset and idle: rst_n=0, then 1 → in_ready=1, out_valid=0, out_data=0, busy=0; holds idle with in_valid=0.
- FIPS-197 C.1 vector, LANES=4, forward:
  - Stimulus: in_data bytes 00,10,20,...,f0 (byte i = 16*i), in_inv=0.
  - Response: out_data bytes 63,ca,b7,04,09,53,d0,51,cd,60,e0,e7,ba,70,e1,8c; out_valid 4 edges after accept.
- Inverse round-trip, all LANES in {1,2,4,8,16}:
  - Feed that output back with in_inv=1 → bytes 00,10,...,f0.
  - Check latency of 16/8/4/2/1 edges respectively.
  - Spot check forward: 53→ed, ff→16. Spot check inverse: 63→00, 16→ff.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_data stable, out_valid=1, in_ready=0; a new in_valid is not accepted.
  - Raise out_ready → IDLE next edge; the new block is then accepted.
- Reset mid-operation: pull rst_n low on the 2nd RUN cycle (LANES=1) → all outputs at reset values asynchronously; after release no out_valid, and the next block completes correctly.
- Exhaustive table check, LANES=16: sweep 16 blocks covering all 256 byte values in both modes against the golden model; back-to-back with out_ready=1 → one result every 3 cycles.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine for a 128-bit state.
// LANES bytes are substituted per cycle; a block completes in 16/LANES cycles.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NB = 16 / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  // Byte x lives at bits [8*(255-x) +: 8]; entry 0 is the leftmost byte.
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    int idx;
    idx = 8 * (255 - int'(b));
    return inv ? INV_SBOX[idx +: 8] : FWD_SBOX[idx +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    res_q, res_d;
  int unsigned     base;

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    work_d  = work_q;
    res_d   = res_q;
    base    = int'(cnt_q) * LANES;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(base+l) +: 8] = sub_byte(work_q[8*(base+l) +: 8], inv_q);
        end
        if (cnt_q == CW'(NB - 1)) begin
          // Result register snapshots the finished block so out_data survives the next RUN.
          res_d   = work_d;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath
  // registers are reset too so out_data reads zero straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal LANES value sharing stimulus,
// a per-instance scoreboard driven from an arithmetic (GF(2^8)) S-box model.
module tb_sub_bytes_engine;

  localparam logic [127:0] C1_IN  = 128'hf0e0d0c0b0a090807060504030201000;
  localparam logic [127:0] C1_OUT = 128'h8ce170bae7e060cd51d0530904b7ca63;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic         out_ready;
  logic [127:0] in_data;
  logic [4:0]   rdy, ov, bz;
  logic [127:0] od [5];

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];
  logic [127:0] sbq [5][$];
  int           last_hs [5];
  bit           b2b_en = 1'b0;
  logic [127:0] res_d [5];
  int           lat [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .in_data  (in_data),
      .in_inv   (in_inv),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g]),
      .busy     (bz[g])
    );
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      fwd_t[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Inputs only move at posedge+1, so at the negedge the coming edge's handshakes are known.
  task automatic sb_monitor();
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        for (int g = 0; g < 5; g++) begin
          sbq[g].delete();
          last_hs[g] = -1;
        end
      end else begin
        for (int g = 0; g < 5; g++) begin
          if (out_ready && ov[g]) begin
            checks++;
            if (sbq[g].size() == 0) begin
              errors++;
              $display("FAIL sb_unexpected_out lanes=%0d got=%h expected=none", 1 << g, od[g]);
            end else begin
              exp = sbq[g].pop_front();
              if (od[g] !== exp) begin
                errors++;
                $display("FAIL sb_data lanes=%0d got=%h expected=%h", 1 << g, od[g], exp);
              end
            end
            if (g == 4 && b2b_en && last_hs[4] >= 0) begin
              checks++;
              if (cyc - last_hs[4] != 3) begin
                errors++;
                $display("FAIL b2b_interval got=%0d expected=3", cyc - last_hs[4]);
              end
            end
            last_hs[g] = cyc;
          end
          if (in_valid && rdy[g]) sbq[g].push_back(model(in_data, in_inv));
        end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (rdy !== 5'h1f && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (rdy !== 5'h1f) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout in_ready=%b expected=11111", nm, rdy);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (rdy !== 5'h1f || ov !== 5'h00 || bz !== 5'h00) begin
      errors++;
      $display("FAIL %s_ctrl in_ready=%b out_valid=%b busy=%b expected 11111/00000/00000", nm, rdy, ov, bz);
    end
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (od[g] !== 128'h0) begin
        errors++;
        $display("FAIL %s_out_data lanes=%0d got=%h expected=0", nm, 1 << g, od[g]);
      end
    end
  endtask

  // One block into every instance at the same edge; records latency and result per instance.
  task automatic run_all(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string nm);
    bit seen [5];
    wait_idle(nm);
    @(posedge clk); #1;
    in_data = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_inv = ~inv; in_data = ~d;
    for (int g = 0; g < 5; g++) begin seen[g] = 1'b0; lat[g] = -1; res_d[g] = 'x; end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 5; g++)
        if (ov[g] && !seen[g]) begin
          seen[g] = 1'b1; lat[g] = n; res_d[g] = od[g];
        end
    end
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (lat[g] != (16 >> g)) begin
        errors++;
        $display("FAIL %s_latency lanes=%0d got=%0d expected=%0d", nm, 1 << g, lat[g], 16 >> g);
      end
      checks++;
      if (res_d[g] !== exp) begin
        errors++;
        $display("FAIL %s_data lanes=%0d got=%h expected=%h", nm, 1 << g, res_d[g], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check_reset_outputs("reset_asserted");
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_c1_vector();
    run_all(C1_IN, 1'b0, C1_OUT, "c1_fwd");
  endtask

  task automatic test_inverse_roundtrip();
    run_all(C1_OUT, 1'b1, C1_IN, "c1_inv");
  endtask

  task automatic test_spot();
    logic [127:0] d;
    d = rand128();
    d[15:0] = 16'hff53;
    run_all(d, 1'b0, model(d, 1'b0), "spot_fwd");
    checks++;
    if (res_d[2][15:0] !== 16'h16ed) begin
      errors++;
      $display("FAIL spot_fwd_bytes got=%h expected=16ed", res_d[2][15:0]);
    end
    d = rand128();
    d[15:0] = 16'h1663;
    run_all(d, 1'b1, model(d, 1'b1), "spot_inv");
    checks++;
    if (res_d[2][15:0] !== 16'hff00) begin
      errors++;
      $display("FAIL spot_inv_bytes got=%h expected=ff00", res_d[2][15:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, held;
    int n;
    d1 = rand128(); d2 = rand128();
    wait_idle("bp");
    @(posedge clk); #1;
    out_ready = 1'b0; in_data = d1; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = d2; in_inv = 1'b1;
    n = 0;
    while (!ov[2] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    held = od[2];
    checks++;
    if (held !== model(d1, 1'b0)) begin
      errors++;
      $display("FAIL bp_result got=%h expected=%h", held, model(d1, 1'b0));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[2] !== 1'b1 || rdy[2] !== 1'b0 || od[2] !== held) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b data=%h expected 1/0/%h",
                 i, ov[2], rdy[2], od[2], held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy[2] !== 1'b1 || ov[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b expected 1/0", rdy[2], ov[2]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (bz[2] !== 1'b1 || rdy[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_new_accept busy=%b in_ready=%b expected 1/0", bz[2], rdy[2]);
    end
    wait_idle("bp_end");
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    bit saw_valid;
    wait_idle("rst_mid");
    @(posedge clk); #1;
    in_data = rand128(); in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_async");
    @(negedge clk); #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov !== 5'h00) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL rst_mid_no_out_valid got=1 expected=0");
    end
    d = rand128();
    run_all(d, 1'b0, model(d, 1'b0), "rst_mid_next");
  endtask

  task automatic test_exhaustive_b2b();
    logic [127:0] d;
    bit acc;
    int k;
    wait_idle("b2b");
    out_ready = 1'b1;
    last_hs[4] = -1;
    b2b_en = 1'b1;
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * (b % 16) + i);
      in_data = d; in_inv = (b >= 16); in_valid = 1'b1;
      acc = 1'b0; k = 0;
      while (!acc && k < 10) begin
        @(negedge clk);
        if (rdy[4]) acc = 1'b1;
        @(posedge clk); #1;
        k++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL b2b_accept_timeout block=%0d got=no_accept expected=accept", b);
      end
    end
    in_valid = 1'b0;
    wait_idle("b2b_end");
    b2b_en = 1'b0;
  endtask

  initial begin
    build_tables();
    for (int g = 0; g < 5; g++) last_hs[g] = -1;
    rst_n = 1'b0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_c1_vector();
    test_inverse_roundtrip();
    test_spot();
    test_backpressure();
    test_reset_mid();
    test_exhaustive_b2b();
    wait_idle("final");
    @(posedge clk); #1;
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (sbq[g].size() != 0) begin
        errors++;
        $display("FAIL sb_leftover lanes=%0d got=%0d expected=0", 1 << g, sbq[g].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
